iter_div_unit: RTL and testbench

Multicycle radix-2 restoring divider (signed/unsigned) that sits beside the ALU in the ARM core datapath. It replaces the combinational divide path for DIV-class instructions. Decode issues a start pulse with captured operands; the unit holds busy so control can stall PC and register write. When done pulses, its quotient feeds the result mux.

---
 rtl/iter_div_unit_if.sv | 34 +++
 rtl/iter_div_unit.sv | 141 ++++++++++++++
 tb/tb_iter_div_unit.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/iter_div_unit_if.sv
// ============================================================================
//  Module      : iter_div_unit_if
//  Description : Request/result bundle between decode/control and the
//                iterative divider.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface iter_div_unit_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic             is_signed;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             flush;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             div_by_zero;

    modport master (
        output start, is_signed, dividend, divisor, flush,
        input  busy, done, quotient, remainder, div_by_zero
    );

    modport slave (
        input  start, is_signed, dividend, divisor, flush,
        output busy, done, quotient, remainder, div_by_zero
    );
endinterface

`default_nettype wire

// File: rtl/iter_div_unit.sv
// ============================================================================
//  Module      : iter_div_unit
//  Description : Multicycle radix-2 restoring divider, signed/unsigned,
//                WIDTH iterations plus a sign-fixup cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module iter_div_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic              clk,
    input  logic              reset,
    iter_div_unit_if.slave    bus
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] c_cnt_init = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] c_cnt_one  = CNT_W'(1);

    state_t           r_state;
    state_t           w_state_next;

    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_rem;
    logic [WIDTH-1:0] r_quo;
    logic [WIDTH-1:0] r_dvsr;
    logic [WIDTH-1:0] r_dvnd_orig;
    logic             r_sign_q;
    logic             r_sign_r;
    logic             r_zero;
    logic [WIDTH-1:0] r_quotient;
    logic [WIDTH-1:0] r_remainder;
    logic             r_dbz;

    logic [WIDTH-1:0] w_dvnd_abs;
    logic [WIDTH-1:0] w_dvsr_abs;
    logic [WIDTH:0]   w_rem_sh;
    logic [WIDTH:0]   w_diff;
    logic             w_borrow;
    logic [WIDTH-1:0] w_rem_next;
    logic [WIDTH-1:0] w_q_fix;
    logic [WIDTH-1:0] w_r_fix;
    logic             w_unused;

    assign w_dvnd_abs = (bus.is_signed && bus.dividend[WIDTH-1]) ? -bus.dividend : bus.dividend;
    assign w_dvsr_abs = (bus.is_signed && bus.divisor[WIDTH-1])  ? -bus.divisor  : bus.divisor;

    // Shifted partial remainder can reach 2*|divisor|-1, so the trial
    // subtraction needs one extra bit; the result always fits WIDTH bits.
    assign w_rem_sh   = {r_rem, r_quo[WIDTH-1]};
    assign w_borrow   = (w_rem_sh < {1'b0, r_dvsr});
    assign w_diff     = w_rem_sh - {1'b0, r_dvsr};
    assign w_rem_next = w_borrow ? w_rem_sh[WIDTH-1:0] : w_diff[WIDTH-1:0];
    assign w_unused   = w_diff[WIDTH];

    assign w_q_fix = r_sign_q ? -r_quo : r_quo;
    assign w_r_fix = r_sign_r ? -r_rem : r_rem;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: if (bus.start) w_state_next = S_RUN;
            S_RUN: begin
                if (bus.flush)          w_state_next = S_IDLE;
                else if (r_cnt == '0)   w_state_next = S_FIX;
            end
            S_FIX:  w_state_next = bus.flush ? S_IDLE : S_DONE;
            S_DONE: w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt       <= '0;
            r_rem       <= '0;
            r_quo       <= '0;
            r_dvsr      <= '0;
            r_dvnd_orig <= '0;
            r_sign_q    <= 1'b0;
            r_sign_r    <= 1'b0;
            r_zero      <= 1'b0;
            r_quotient  <= '0;
            r_remainder <= '0;
            r_dbz       <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_sign_q    <= bus.is_signed & (bus.dividend[WIDTH-1] ^ bus.divisor[WIDTH-1]);
                        r_sign_r    <= bus.is_signed & bus.dividend[WIDTH-1];
                        r_quo       <= w_dvnd_abs;
                        r_dvsr      <= w_dvsr_abs;
                        r_dvnd_orig <= bus.dividend;
                        r_zero      <= (bus.divisor == '0);
                        r_rem       <= '0;
                        r_cnt       <= c_cnt_init;
                    end
                end
                S_RUN: begin
                    r_rem <= w_rem_next;
                    r_quo <= {r_quo[WIDTH-2:0], ~w_borrow};
                    r_cnt <= r_cnt - c_cnt_one;
                end
                S_FIX: begin
                    if (!bus.flush) begin
                        r_quotient  <= r_zero ? '0 : w_q_fix;
                        r_remainder <= r_zero ? r_dvnd_orig : w_r_fix;
                        r_dbz       <= r_zero;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.busy        = (r_state != S_IDLE);
    assign bus.done        = (r_state == S_DONE);
    assign bus.quotient    = r_quotient;
    assign bus.remainder   = r_remainder;
    assign bus.div_by_zero = r_dbz;

endmodule

`default_nettype wire

// File: tb/tb_iter_div_unit.sv
// ============================================================================
//  Module      : tb_iter_div_unit
//  Description : Self-checking bench for iter_div_unit: directed vectors,
//                control corner cases and randomized ops against a model.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_iter_div_unit;

    localparam int WIDTH = 32;

    logic clk = 1'b0;
    logic reset;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    iter_div_unit_if #(.WIDTH(WIDTH)) bus ();

    iter_div_unit #(.WIDTH(WIDTH), .CNT_W(6)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    typedef struct {
        logic        s;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] q;
        logic [31:0] r;
        logic        z;
    } vec_t;

    vec_t vt[10];

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%h required=%h", nm, act, exp);
        end
    endtask

    // Truncating division computed with 64-bit arithmetic.
    function automatic void model(input logic s, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] q, output logic [31:0] r, output logic z);
        longint sa, sb, sq, sr;
        if (b == 32'd0) begin
            q = 32'd0; r = a; z = 1'b1;
        end else begin
            if (s) begin
                sa = longint'($signed(a));
                sb = longint'($signed(b));
            end else begin
                sa = longint'({32'd0, a});
                sb = longint'({32'd0, b});
            end
            sq = sa / sb;
            sr = sa % sb;
            q  = sq[31:0];
            r  = sr[31:0];
            z  = 1'b0;
        end
    endfunction

    // One full op: checks busy, done latency, single pulse and results.
    task automatic run_op(input string nm, input logic s, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] eq, input logic [31:0] er, input logic ez, input bit noise);
        int k;
        bit seen;
        @(negedge clk);
        bus.start = 1'b1; bus.is_signed = s; bus.dividend = a; bus.divisor = b;
        @(negedge clk);
        bus.start = 1'b0;
        bus.dividend = $urandom; bus.divisor = $urandom; bus.is_signed = 1'($urandom_range(0, 1));
        check({nm, "_busy_after_accept"}, {63'd0, bus.busy}, 64'd1);
        seen = 1'b0;
        k = 0;
        while (!seen && k < WIDTH + 8) begin
            bus.start = (noise && (k % 5 == 2)) ? 1'b1 : 1'b0;
            if (noise) begin
                bus.dividend = $urandom; bus.divisor = $urandom;
            end
            @(negedge clk);
            k++;
            if (bus.done) seen = 1'b1;
        end
        check({nm, "_done_latency"}, 64'(k), 64'(WIDTH + 1));
        check({nm, "_quotient"}, {32'd0, bus.quotient}, {32'd0, eq});
        check({nm, "_remainder"}, {32'd0, bus.remainder}, {32'd0, er});
        check({nm, "_div_by_zero"}, {63'd0, bus.div_by_zero}, {63'd0, ez});
        // A start during the DONE cycle must not be accepted.
        bus.start = noise;
        @(negedge clk);
        bus.start = 1'b0;
        check({nm, "_busy_after_done"}, {63'd0, bus.busy}, 64'd0);
        check({nm, "_single_done"}, {63'd0, bus.done}, 64'd0);
    endtask

    logic [31:0] ra, rb, rq, rr, pq, pr;
    logic        rs, rz, pz;
    int          cat;
    bit          flush_done_seen;

    initial begin
        #500000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vt[0] = '{1'b0, 32'd100,       32'd7,          32'd14,         32'd2,          1'b0};
        vt[1] = '{1'b1, 32'hFFFFFFF9,  32'h00000002,   32'hFFFFFFFD,   32'hFFFFFFFF,   1'b0};
        vt[2] = '{1'b1, 32'h00000007,  32'hFFFFFFFE,   32'hFFFFFFFD,   32'h00000001,   1'b0};
        vt[3] = '{1'b1, 32'h80000000,  32'hFFFFFFFF,   32'h80000000,   32'h00000000,   1'b0};
        vt[4] = '{1'b0, 32'hFFFFFFFF,  32'h00000010,   32'h0FFFFFFF,   32'h0000000F,   1'b0};
        vt[5] = '{1'b1, 32'd5,         32'd0,          32'd0,          32'd5,          1'b1};
        vt[6] = '{1'b0, 32'd5,         32'd0,          32'd0,          32'd5,          1'b1};
        vt[7] = '{1'b0, 32'd9,         32'd3,          32'd3,          32'd0,          1'b0};
        vt[8] = '{1'b0, 32'h80000000,  32'hFFFFFFFF,   32'h00000000,   32'h80000000,   1'b0};
        vt[9] = '{1'b1, 32'hFFFFFF9C,  32'hFFFFFFF9,   32'd14,         32'hFFFFFFFE,   1'b0};

        bus.start = 1'b0; bus.is_signed = 1'b0; bus.dividend = '0; bus.divisor = '0; bus.flush = 1'b0;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        check("reset_busy", {63'd0, bus.busy}, 64'd0);
        check("reset_done", {63'd0, bus.done}, 64'd0);
        check("reset_quotient", {32'd0, bus.quotient}, 64'd0);
        check("reset_remainder", {32'd0, bus.remainder}, 64'd0);
        check("reset_dbz", {63'd0, bus.div_by_zero}, 64'd0);
        reset = 1'b0;

        for (int i = 0; i < 10; i++)
            run_op($sformatf("vec%0d", i), vt[i].s, vt[i].a, vt[i].b, vt[i].q, vt[i].r, vt[i].z, 1'b0);

        // Starts with new operands while busy (and in DONE) are ignored.
        run_op("noise_100_7", 1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 1'b1);

        // Flush at RUN cycle 10: no done, previous outputs held.
        pq = bus.quotient; pr = bus.remainder; pz = bus.div_by_zero;
        @(negedge clk);
        bus.start = 1'b1; bus.is_signed = 1'b0; bus.dividend = 32'd1000; bus.divisor = 32'd3;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (9) @(negedge clk);
        bus.flush = 1'b1;
        @(negedge clk);
        bus.flush = 1'b0;
        check("flush_busy_drop", {63'd0, bus.busy}, 64'd0);
        flush_done_seen = 1'b0;
        for (int i = 0; i < WIDTH + 6; i++) begin
            @(negedge clk);
            if (bus.done) flush_done_seen = 1'b1;
        end
        check("flush_no_done", {63'd0, flush_done_seen}, 64'd0);
        check("flush_q_held", {32'd0, bus.quotient}, {32'd0, pq});
        check("flush_r_held", {32'd0, bus.remainder}, {32'd0, pr});
        check("flush_z_held", {63'd0, bus.div_by_zero}, {63'd0, pz});

        // Async reset mid-RUN clears outputs without waiting for a clock edge.
        run_op("pre_reset", 1'b0, 32'd5, 32'd0, 32'd0, 32'd5, 1'b1, 1'b0);
        @(negedge clk);
        bus.start = 1'b1; bus.is_signed = 1'b1; bus.dividend = 32'd77; bus.divisor = 32'd5;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (5) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        check("async_reset_busy", {63'd0, bus.busy}, 64'd0);
        check("async_reset_q", {32'd0, bus.quotient}, 64'd0);
        check("async_reset_r", {32'd0, bus.remainder}, 64'd0);
        check("async_reset_dbz", {63'd0, bus.div_by_zero}, 64'd0);
        @(negedge clk);
        reset = 1'b0;
        run_op("after_reset", 1'b1, 32'hFFFFFFB3, 32'd5, 32'hFFFFFFF1, 32'hFFFFFFFE, 1'b0, 1'b0);

        for (int i = 0; i < 30; i++) begin
            cat = int'($urandom_range(0, 5));
            rs  = 1'($urandom_range(0, 1));
            ra  = $urandom;
            rb  = $urandom;
            case (cat)
                0: rb = 32'd0;
                1: rb = 32'($urandom_range(1, 20));
                2: begin ra = 32'h80000000; rb = 32'hFFFFFFFF; end
                3: ra = 32'($urandom_range(0, 1000));
                default: ;
            endcase
            model(rs, ra, rb, rq, rr, rz);
            run_op($sformatf("rand%0d", i), rs, ra, rb, rq, rr, rz, (i % 4 == 1));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
